// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the host UART transmitter between NUM_REQ sources, one whole message at a time.
// Optional macro UART_ARB_PRIO0_EN: source 0 wins every arbitration it takes part in, without moving rr_ptr.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_latch,
    output logic [7:0]           tx_data,
    input  logic                 tx_empty,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 abort
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SEND,
        DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]      stall_q, stall_d;
    logic               last_q, last_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               tx_latch_q, tx_latch_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               abort_q, abort_d;

    logic [IW-1:0]      arb_pick;
    logic               owner_valid;
    logic               owner_last;
    logic [7:0]         owner_data;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    // First requester at or after start, walking upward and wrapping past NUM_REQ-1.
    function automatic logic [IW-1:0] rr_select(input logic [NUM_REQ-1:0] valid,
                                                input logic [IW-1:0]      start);
        logic [IW-1:0] pick;
        logic [IW-1:0] idx;
        logic          found;
        pick  = start;
        idx   = start;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign owner_data  = req_data[{owner_q, 3'b000} +: 8];

    always_comb begin
        arb_pick = rr_select(req_valid, rr_ptr_q);
`ifdef UART_ARB_PRIO0_EN
        if (req_valid[0]) begin
            arb_pick = '0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        stall_d     = stall_q;
        last_d      = last_q;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        req_ready_d = '0;
        tx_latch_d  = 1'b0;
        abort_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d = arb_pick;
                    busy_d  = 1'b1;
                    stall_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (owner_valid) begin
                    tx_data_d            = owner_data;
                    last_d               = owner_last;
                    req_ready_d[owner_q] = 1'b1;
                    tx_latch_d           = 1'b1;
                    stall_d              = '0;
                    state_d              = SEND;
                end else if (stall_q == SW'(STALL_LIMIT - 1)) begin
                    // Owner went silent mid-frame: release the UART so others are not starved.
                    abort_d  = 1'b1;
                    busy_d   = 1'b0;
                    rr_ptr_d = wrap_inc(owner_q);
                    state_d  = IDLE;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            SEND: begin
                if (!tx_empty) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tx_empty) begin
                    if (last_q) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
`ifdef UART_ARB_PRIO0_EN
                        if (owner_q != '0) begin
                            rr_ptr_d = wrap_inc(owner_q);
                        end
`else
                        rr_ptr_d = wrap_inc(owner_q);
`endif
                    end else begin
                        state_d = GRANT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            stall_q     <= '0;
            last_q      <= 1'b0;
            req_ready_q <= '0;
            tx_latch_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_q     <= stall_d;
            last_q      <= last_d;
            req_ready_q <= req_ready_d;
            tx_latch_q  <= tx_latch_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            abort_q     <= abort_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_latch  = tx_latch_q;
    assign tx_data   = tx_data_q;
    assign grant_id  = 3'(owner_q);
    assign busy      = busy_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized frames from queue-backed sources into a simple UART model,
// compared against a frame-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int STALL = 200;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            tx_latch;
    logic [7:0]      tx_data;
    logic            tx_empty;
    logic [2:0]      grant_id;
    logic            busy;
    logic            abort;

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .STALL_LIMIT (STALL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_latch  (tx_latch),
        .tx_data   (tx_data),
        .tx_empty  (tx_empty),
        .grant_id  (grant_id),
        .busy      (busy),
        .abort     (abort)
    );

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int cyc        = 0;
    int baudDiv    = 3;

    logic [7:0] srcData[NR][$];
    logic       srcLast[NR][$];
    logic [7:0] modelBytes[NR][$];
    logic       modelLast[NR][$];
    int         modelRr = 0;

    logic [7:0] expStream[$];
    logic [7:0] actStream[$];
    int         expOwners[$];
    int         actOwners[$];
    int         latchCycs[$];
    int         gaps[$];
    int         readyCount;
    int         abortCount;
    int         abortGap;
    logic       abortBusy;
    int         lastRiseCyc;
    int         msgLatches;
    logic       prevBusy;
    logic       prevEmpty;
    logic [7:0] uartByte;
    int         uartCnt;

    logic [7:0] frame[$];
    int         startCyc;
    int         goodGaps;
    logic       reached;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitorStep();
        if (busy && !prevBusy) begin
            actOwners.push_back(int'(grant_id));
            msgLatches = 0;
        end
        if (req_ready != '0) begin
            readyCount++;
            checkOutput("ready_onehot", 64'(req_ready), 64'(1) << grant_id);
            checkOutput("ready_with_latch", 64'(tx_latch), 64'd1);
        end
        if (tx_latch) begin
            checkOutput("latch_while_idle_uart", 64'(tx_empty), 64'd1);
            actStream.push_back(tx_data);
            latchCycs.push_back(cyc);
            if (msgLatches > 0) gaps.push_back(cyc - lastRiseCyc);
            msgLatches++;
        end else if (!tx_empty && reset) begin
            checkOutput("tx_data_stable", 64'(tx_data), 64'(uartByte));
        end
        if (tx_empty && !prevEmpty) lastRiseCyc = cyc;
        if (abort) begin
            abortCount++;
            abortGap  = cyc - lastRiseCyc;
            abortBusy = busy;
        end
        prevBusy  = busy;
        prevEmpty = tx_empty;
    endtask

    task automatic uartStep();
        if (uartCnt > 0) begin
            uartCnt--;
            if (uartCnt == 0) tx_empty = 1'b1;
        end
        if (tx_latch) begin
            uartByte = tx_data;
            tx_empty = 1'b0;
            uartCnt  = baudDiv;
        end
    endtask

    task automatic driveSources();
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i] && srcData[i].size() > 0) begin
                void'(srcData[i].pop_front());
                void'(srcLast[i].pop_front());
            end
            if (srcData[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = srcData[i][0];
                req_last[i]        = srcLast[i][0];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // Environment: sample outputs first, then let the UART and the sources react, all on the falling edge.
    initial begin
        tx_empty    = 1'b1;
        uartCnt     = 0;
        uartByte    = 8'h00;
        prevBusy    = 1'b0;
        prevEmpty   = 1'b1;
        lastRiseCyc = 0;
        msgLatches  = 0;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            monitorStep();
            uartStep();
            driveSources();
        end
    end

    task automatic applyStimulus(input int src, input logic [7:0] bytes[$], input bit withLast);
        for (int k = 0; k < bytes.size(); k++) begin
            srcData[src].push_back(bytes[k]);
            srcLast[src].push_back(withLast && (k == bytes.size() - 1));
        end
    endtask

    task automatic addFrame(input int src, input logic [7:0] bytes[$]);
        applyStimulus(src, bytes, 1'b1);
        for (int k = 0; k < bytes.size(); k++) begin
            modelBytes[src].push_back(bytes[k]);
            modelLast[src].push_back(k == bytes.size() - 1);
        end
    endtask

    task automatic startBatch();
        actStream.delete();
        actOwners.delete();
        expStream.delete();
        expOwners.delete();
        latchCycs.delete();
        gaps.delete();
        readyCount = 0;
        abortCount = 0;
        abortGap   = 0;
        abortBusy  = 1'b1;
    endtask

    // Reference: whole frames leave in round-robin order over sources that still hold a frame.
    task automatic predict();
        int   pick;
        logic l;
        forever begin
            pick = -1;
`ifdef UART_ARB_PRIO0_EN
            if (modelBytes[0].size() > 0) pick = 0;
`endif
            for (int k = 0; k < NR; k++) begin
                if (pick < 0 && modelBytes[(modelRr + k) % NR].size() > 0) pick = (modelRr + k) % NR;
            end
            if (pick < 0) break;
            expOwners.push_back(pick);
            do begin
                expStream.push_back(modelBytes[pick].pop_front());
                l = modelLast[pick].pop_front();
            end while (!l);
`ifdef UART_ARB_PRIO0_EN
            if (pick != 0) modelRr = (pick + 1) % NR;
`else
            modelRr = (pick + 1) % NR;
`endif
        end
    endtask

    function automatic bit allEmpty();
        for (int i = 0; i < NR; i++) begin
            if (srcData[i].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic waitIdle(input string tag, input int maxCycles);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < maxCycles) begin
            @(negedge clk);
            #1;
            n++;
            done = !busy && tx_empty && allEmpty();
        end
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, "_len"}, 64'(actStream.size()), 64'(expStream.size()));
        for (int i = 0; i < expStream.size() && i < actStream.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), 64'(actStream[i]), 64'(expStream[i]));
        end
        checkOutput({tag, "_msgs"}, 64'(actOwners.size()), 64'(expOwners.size()));
        for (int i = 0; i < expOwners.size() && i < actOwners.size(); i++) begin
            checkOutput($sformatf("%s_owner%0d", tag, i), 64'(actOwners[i]), 64'(expOwners[i]));
        end
    endtask

    task automatic runBatch(input string tag);
        predict();
        waitIdle(tag, 5000);
        compareAll(tag);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_grant", 64'(grant_id), 64'd0);
        checkOutput("rst_txdata", 64'(tx_data), 64'd0);
        checkOutput("rst_latch", 64'(tx_latch), 64'd0);
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_abort", 64'(abort), 64'd0);
        reset = 1'b1;

        $display("[TB] single 3-byte frame from source 0");
        startBatch();
        startCyc = cyc;
        frame = {8'h6d, 8'h0a, 8'h00};
        addFrame(0, frame);
        runBatch("t1");
        // One cycle for the source to drive, then arbitrate, then latch.
        checkOutput("t1_first_latency", 64'(latchCycs[0] - startCyc), 64'd3);

        $display("[TB] sources 1 and 2 together");
        startBatch();
        frame = {8'h11, 8'h12, 8'h13, 8'h14};
        addFrame(1, frame);
        frame = {8'h21, 8'h22, 8'h23, 8'h24};
        addFrame(2, frame);
        runBatch("t2");

        $display("[TB] wrap from source 3 to source 0");
        startBatch();
        frame = {8'h31};
        addFrame(3, frame);
        runBatch("t3a");
        startBatch();
        frame = {8'h01, 8'h02};
        addFrame(0, frame);
        frame = {8'h35, 8'h36};
        addFrame(3, frame);
        runBatch("t3b");
        startBatch();
        frame = {8'h03};
        addFrame(0, frame);
        runBatch("t3c");
        startBatch();
        frame = {8'h04, 8'h05};
        addFrame(0, frame);
        frame = {8'h15, 8'h16};
        addFrame(1, frame);
        runBatch("t3d");

        $display("[TB] source 2 stalls mid-frame");
        startBatch();
        frame = {8'h2a, 8'h2b};
        applyStimulus(2, frame, 1'b0);
        frame = {8'h3a, 8'h3b, 8'h3c};
        applyStimulus(3, frame, 1'b1);
        expStream = {8'h2a, 8'h2b, 8'h3a, 8'h3b, 8'h3c};
        expOwners = {2, 3};
        waitIdle("t4", STALL + 2000);
        compareAll("t4");
        checkOutput("t4_abort_count", 64'(abortCount), 64'd1);
        checkOutput("t4_abort_gap", 64'(abortGap), 64'(STALL));
        checkOutput("t4_abort_busy", 64'(abortBusy), 64'd0);
        modelRr = 0;

        $display("[TB] reset during a 5-byte frame");
        startBatch();
        frame = {8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        applyStimulus(1, frame, 1'b1);
        reached = 1'b0;
        for (int n = 0; n < 2000 && !reached; n++) begin
            @(negedge clk);
            #1;
            reached = (latchCycs.size() >= 3) && !tx_empty;
        end
        checkOutput("t5_reached_drain", 64'(reached), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t5_rst_busy", 64'(busy), 64'd0);
        checkOutput("t5_rst_latch", 64'(tx_latch), 64'd0);
        checkOutput("t5_rst_ready", 64'(req_ready), 64'd0);
        checkOutput("t5_rst_txdata", 64'(tx_data), 64'd0);
        checkOutput("t5_rst_grant", 64'(grant_id), 64'd0);
        checkOutput("t5_rst_abort", 64'(abort), 64'd0);
        for (int i = 0; i < NR; i++) begin
            srcData[i].delete();
            srcLast[i].delete();
        end
        repeat (baudDiv + 3) @(negedge clk);
        #1;
        reset   = 1'b1;
        modelRr = 0;
        startBatch();
        frame = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        addFrame(1, frame);
        runBatch("t5");

        $display("[TB] 11-byte frame at slow baud");
        baudDiv = 10;
        startBatch();
        startCyc = cyc;
        frame = {8'h62, 8'h0c, 8'h08, 8'hf0, 8'h12, 8'h34, 8'h50, 8'hde, 8'had, 8'hbe, 8'hef};
        addFrame(2, frame);
        runBatch("t6");
        checkOutput("t6_latches", 64'(latchCycs.size()), 64'd11);
        checkOutput("t6_readies", 64'(readyCount), 64'd11);
        checkOutput("t6_first_latency", 64'(latchCycs[0] - startCyc), 64'd3);
        goodGaps = 0;
        foreach (gaps[i]) if (gaps[i] == 1) goodGaps++;
        checkOutput("t6_gap_count", 64'(gaps.size()), 64'd10);
        checkOutput("t6_gaps_one_cycle", 64'(goodGaps), 64'd10);

        for (int r = 0; r < 6; r++) begin
            $display("[TB] random batch %0d", r);
            baudDiv = int'($urandom_range(1, 6));
            startBatch();
            for (int s = 0; s < NR; s++) begin
                for (int f = 0; f < int'($urandom_range(0, 2)); f++) begin
                    frame.delete();
                    for (int b = 0; b < int'($urandom_range(1, 6)); b++) frame.push_back(8'($urandom));
                    addFrame(s, frame);
                end
            end
            runBatch($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
